// File: rtl/counter_10bit.sv
// Free-running up-counter with a configurable width, terminal value and step.
// Produces a terminal-count decode and a registered one-cycle wrap pulse.
module counter_10bit #(
    parameter int unsigned     WIDTH     = 10,
    parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP      = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    // Reject configurations that cannot produce a well-defined sequence.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "counter_10bit: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (MAX_VALUE >= (64'd1 << WIDTH)) begin : g_bad_max
        $fatal(1, "counter_10bit: MAX_VALUE=%0d does not fit in WIDTH=%0d", MAX_VALUE, WIDTH);
    end
    if (STEP == 0 || STEP > MAX_VALUE + 64'd1) begin : g_bad_step
        $fatal(1, "counter_10bit: STEP=%0d outside 1..MAX_VALUE+1", STEP);
    end

    localparam logic [WIDTH:0]   L_MAX    = MAX_VALUE[WIDTH:0];
    localparam logic [WIDTH:0]   L_MAX_P1 = L_MAX + (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   L_STEP   = STEP[WIDTH:0];
    localparam logic [WIDTH-1:0] L_TC     = MAX_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH:0]   w_sum;
    logic             w_wraps;
    logic [WIDTH-1:0] w_next;

    // One extra bit keeps the carry so the terminal compare is exact.
    assign w_sum   = {1'b0, r_count} + L_STEP;
    assign w_wraps = (w_sum > L_MAX);
    assign w_next  = w_wraps ? WIDTH'(w_sum - L_MAX_P1) : w_sum[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is checked first so it overrides a wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= w_wraps;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = (r_count == L_TC);

endmodule

// File: tb/tb_counter_10bit.sv
// Directed self-checking bench: default counter plus two small configurations
// (mod-10 step 1 and mod-10 step 3) sharing one clock and reset.
module tb_counter_10bit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] count_d;
    logic       tc_d, wrap_d;
    logic [3:0] count_a, count_b;
    logic       tc_a, wrap_a, tc_b, wrap_b;

    int checks = 0;
    int errors = 0;

    // Hand-computed sequence for MAX_VALUE=9, STEP=3 after the first reset.
    int exp_b_cnt [10] = '{3, 6, 9, 2, 5, 8, 1, 4, 7, 0};
    int exp_b_wrap[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};

    always #5 clk = ~clk;

    counter_10bit u_dut_def (
        .clk(clk), .reset(reset), .count(count_d), .tc(tc_d), .wrap(wrap_d)
    );

    counter_10bit #(.WIDTH(4), .MAX_VALUE(9), .STEP(1)) u_dut_a (
        .clk(clk), .reset(reset), .count(count_a), .tc(tc_a), .wrap(wrap_a)
    );

    counter_10bit #(.WIDTH(4), .MAX_VALUE(9), .STEP(3)) u_dut_b (
        .clk(clk), .reset(reset), .count(count_b), .tc(tc_b), .wrap(wrap_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset on the edge at t=5, release at t=10.
        tick();
        check("rst_count", 32'(count_d), 0);
        check("rst_wrap", 32'(wrap_d), 0);
        check("rst_tc", 32'(tc_d), 0);
        #4 reset = 1'b0;
        tick();                               // t=16, edge 15
        check("first_inc", 32'(count_d), 1);
        repeat (9) tick();                    // t=106, edge 105
        check("count_10", 32'(count_d), 10);

        // Mid-count reset at t=110, released at t=120.
        #4 reset = 1'b1;
        tick();                               // edge 115
        check("midrst_count", 32'(count_d), 0);
        check("midrst_wrap", 32'(wrap_d), 0);
        #4 reset = 1'b0;
        tick();                               // edge 125
        check("resume_1", 32'(count_d), 1);
        repeat (4) tick();                    // edge 165
        check("resume_5", 32'(count_d), 5);

        // Full default wrap: 1023 -> 0 -> 1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (1023) tick();
        check("max_count", 32'(count_d), 1023);
        check("max_tc", 32'(tc_d), 1);
        check("max_wrap", 32'(wrap_d), 0);
        tick();
        check("wrap_count", 32'(count_d), 0);
        check("wrap_pulse", 32'(wrap_d), 1);
        check("wrap_tc", 32'(tc_d), 0);
        tick();
        check("post_count", 32'(count_d), 1);
        check("post_wrap", 32'(wrap_d), 0);
        check("post_tc", 32'(tc_d), 0);

        // Reset applied on the edge where count sits at 1023.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (1023) tick();
        check("pre_rst_max", 32'(count_d), 1023);
        reset = 1'b1;
        tick();
        check("rst_at_max_count", 32'(count_d), 0);
        check("rst_at_max_wrap", 32'(wrap_d), 0);
        reset = 1'b0;
        tick();
        check("rst_at_max_resume", 32'(count_d), 1);
        check("rst_at_max_nowrap", 32'(wrap_d), 0);

        // Small configurations from a common reset.
        reset = 1'b1;
        tick();
        check("a_rst", 32'(count_a), 0);
        check("b_rst", 32'(count_b), 0);
        check("a_rst_tc", 32'(tc_a), 0);
        reset = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check($sformatf("a_cnt_%0d", i), 32'(count_a), i % 10);
            check($sformatf("a_tc_%0d", i), 32'(tc_a), (i == 9) ? 1 : 0);
            check($sformatf("a_wrap_%0d", i), 32'(wrap_a), (i == 10) ? 1 : 0);
            if (i <= 10) begin
                check($sformatf("b_cnt_%0d", i), 32'(count_b), exp_b_cnt[i-1]);
                check($sformatf("b_wrap_%0d", i), 32'(wrap_b), exp_b_wrap[i-1]);
                check($sformatf("b_tc_%0d", i), 32'(tc_b), (exp_b_cnt[i-1] == 9) ? 1 : 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
